// File: rtl/pipe_reg_chain.sv
// -----------------------------------------------------------------------------
// pipe_reg_chain -- elastic register pipeline of DEPTH stages.
//
// Each stage holds a valid bit and a WIDTH-bit payload. Readiness ripples
// backwards from out_ready through empty stages, so bubbles collapse: a stage
// loads whenever it is empty or the stage after it is moving.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   res        : synchronous active-high reset (clears valid and data)
//   en         : global enable; 0 freezes the whole chain
//   flush      : synchronous discard of every in-flight entry (data kept)
//   in_valid   : upstream presents in_data
//   in_data    : upstream payload
//   in_ready   : chain accepts in_data this cycle
//   out_valid  : out_data holds a valid entry
//   out_data   : payload of the last stage (always driven, even when invalid)
//   out_ready  : downstream accepts this cycle
//   count      : registered number of valid stages
//
// Priority of control: res > flush > en.
// -----------------------------------------------------------------------------

// One pipeline stage: valid/data register with reset > flush > load priority.
module pipe_reg_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             res_i,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic             v_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             v_d_o,
  output logic             v_q_o,
  output logic [WIDTH-1:0] d_q_o
);

  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (res_i) begin
      v_d = 1'b0;
      d_d = '0;
    end else if (flush_i) begin
      // flush drops the entry but leaves the payload register untouched
      v_d = 1'b0;
    end else if (load_i) begin
      v_d = v_i;
      d_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (res_i) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign v_d_o = v_d;
  assign v_q_o = v_q;
  assign d_q_o = d_q;

endmodule

module pipe_reg_chain #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0]            v_q;     // per-stage valid (registered)
  logic [DEPTH-1:0]            v_d;     // per-stage valid (next state)
  logic [DEPTH-1:0]            v_src;   // valid offered to each stage
  logic [DEPTH-1:0][WIDTH-1:0] d_q;     // per-stage payload
  logic [DEPTH-1:0][WIDTH-1:0] d_src;   // payload offered to each stage
  logic [DEPTH:0]              rdy;     // rdy[k]: stage k may load
  logic                        run;     // chain is allowed to move
  logic [CW-1:0]               count_q, count_d;

  assign run = en & ~flush & ~res;

  // Readiness ripples from the output back to the input; an empty stage is
  // always ready, which is what lets bubbles close up under backpressure.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int k = DEPTH-1; k >= 0; k--)
      rdy[k] = ~v_q[k] | rdy[k+1];
  end

  assign in_ready  = rdy[0] & run;
  assign out_valid = v_q[DEPTH-1] & run;
  assign out_data  = d_q[DEPTH-1];

  // Source of each stage: upstream port for stage 0, predecessor otherwise.
  always_comb begin
    v_src    = '0;
    d_src    = '0;
    v_src[0] = in_valid & in_ready;
    d_src[0] = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      v_src[k] = v_q[k-1];
      d_src[k] = d_q[k-1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_reg_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .res_i   (res),
      .flush_i (flush),
      .load_i  (run & rdy[k]),
      .v_i     (v_src[k]),
      .d_i     (d_src[k]),
      .v_d_o   (v_d[k]),
      .v_q_o   (v_q[k]),
      .d_q_o   (d_q[k])
    );
  end

  // count is the popcount of the next valid vector, registered so it
  // always matches the stage valids after the last edge.
  always_comb begin
    count_d = '0;
    for (int k = 0; k < DEPTH; k++)
      count_d = count_d + CW'(v_d[k]);
  end

  always_ff @(posedge clk) begin
    if (res) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
module tb_pipe_reg_chain;
  localparam int WIDTH = 8;
  localparam int DEPTH = 3;

  logic             clk = 1'b0;
  logic             res, en, flush, in_valid, out_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_ready, out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  logic [WIDTH-1:0] sb[$];

  always #5 clk = ~clk;

  pipe_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .res       (res),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  // Scoreboard monitor: sampled mid-cycle, the handshakes seen here are the
  // ones that complete at the following rising edge.
  always @(negedge clk) begin
    if (res || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        pops++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_out unexpected output got %h want none", out_data);
        end else begin
          logic [WIDTH-1:0] exp;
          exp = sb.pop_front();
          if (out_data !== exp) begin
            errors++;
            $display("FAIL sb_out got %h want %h", out_data, exp);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(in_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    en        = 1'b1;
    for (int i = 0; i < 20 && count != 2'd0; i++) tick();
    #1;
    checks++;
    if (count !== 2'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain count got %0d want 0 (out_valid %b)", count, out_valid);
    end
  endtask

  task automatic test_reset();
    res = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
    tick(); tick();
    #1;
    checks++;
    if (count !== 2'd0 || out_data !== 8'h00) begin
      errors++; $display("FAIL rst_state count %0d data %h want 0 00", count, out_data);
    end
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_hs in_ready %b out_valid %b want 0 0", in_ready, out_valid);
    end
    in_valid = 1'b0;
    res = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_release in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_stream();
    en = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h11;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL stream_ready got %b want 1", in_ready);
    end
    tick(); in_data = 8'h22;
    tick(); in_data = 8'h33;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL stream_early out_valid got %b want 0", out_valid);
    end
    tick(); in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h11) begin
      errors++; $display("FAIL stream_c3 got %b/%h want 1/11", out_valid, out_data);
    end
    tick(); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h22) begin
      errors++; $display("FAIL stream_c4 got %b/%h want 1/22", out_valid, out_data);
    end
    tick(); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h33) begin
      errors++; $display("FAIL stream_c5 got %b/%h want 1/33", out_valid, out_data);
    end
    tick(); #1;
    checks++;
    if (out_valid !== 1'b0 || count !== 2'd0) begin
      errors++; $display("FAIL stream_end out_valid %b count %0d want 0 0", out_valid, count);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
    en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = vals[i];
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL bp_accept%0d in_ready got %b want 1", i, in_ready);
      end
      tick();
    end
    in_data = 8'h44;
    #1;
    checks++;
    if (in_ready !== 1'b0 || count !== 2'd3) begin
      errors++; $display("FAIL bp_full in_ready %b count %0d want 0 3", in_ready, count);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h11) begin
      errors++; $display("FAIL bp_head got %b/%h want 1/11", out_valid, out_data);
    end
    tick(); #1;
    checks++;
    if (in_ready !== 1'b0 || count !== 2'd3) begin
      errors++; $display("FAIL bp_hold in_ready %b count %0d want 0 3", in_ready, count);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_passthru in_ready got %b want 1", in_ready);
    end
    tick(); in_valid = 1'b0;
    #1;
    checks++;
    if (out_data !== 8'h22 || count !== 2'd3) begin
      errors++; $display("FAIL bp_next data %h count %0d want 22 3", out_data, count);
    end
    drain();
  endtask

  task automatic test_bubble();
    en = 1'b1; out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hA1;
    tick(); in_valid = 1'b0;
    tick();
    tick(); in_valid = 1'b1; in_data = 8'hA2;
    tick(); in_valid = 1'b0;
    tick();
    tick();
    #1;
    checks++;
    if (count !== 2'd2 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bubble_pack count %0d in_ready %b want 2 1", count, in_ready);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA1) begin
      errors++; $display("FAIL bubble_head got %b/%h want 1/a1", out_valid, out_data);
    end
    drain();
  endtask

  task automatic test_stall();
    int p0;
    p0 = pops;
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 8'h60 + 8'(i);
      if (i == 3) begin
        en = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || count !== 2'd3) begin
          errors++; $display("FAIL stall_a in_ready %b out_valid %b count %0d want 0 0 3", in_ready, out_valid, count);
        end
        tick(); #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || count !== 2'd3) begin
          errors++; $display("FAIL stall_b in_ready %b out_valid %b count %0d want 0 0 3", in_ready, out_valid, count);
        end
        tick();
        en = 1'b1;
      end
      tick();
    end
    drain();
    checks++;
    if (pops - p0 !== 6) begin
      errors++; $display("FAIL stall_total got %0d want 6", pops - p0);
    end
  endtask

  task automatic test_flush_reset();
    logic [7:0] vals [3] = '{8'h31, 8'h32, 8'h33};
    en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = vals[i];
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (count !== 2'd3) begin
      errors++; $display("FAIL fl_fill count got %0d want 3", count);
    end
    flush = 1'b1; en = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL fl_hs in_ready %b out_valid %b want 0 0", in_ready, out_valid);
    end
    tick(); flush = 1'b0; en = 1'b1;
    #1;
    checks++;
    if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL fl_clear count %0d out_valid %b in_ready %b want 0 0 1", count, out_valid, in_ready);
    end
    checks++;
    if (out_data !== 8'h31) begin
      errors++; $display("FAIL fl_datahold got %h want 31", out_data);
    end
    in_valid = 1'b1; in_data = 8'h55;
    tick(); in_valid = 1'b0;
    #1;
    checks++;
    if (count !== 2'd1) begin
      errors++; $display("FAIL fl_refill count got %0d want 1", count);
    end
    res = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rf_hs in_ready %b out_valid %b want 0 0", in_ready, out_valid);
    end
    tick();
    #1;
    checks++;
    if (count !== 2'd0 || out_data !== 8'h00) begin
      errors++; $display("FAIL rf_state count %0d data %h want 0 00", count, out_data);
    end
    res = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rf_release in_ready got %b want 1", in_ready);
    end
  endtask

  initial begin
    res = 1'b1; en = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_stall();
    test_flush_reset();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover got %0d entries want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_reg_chain.md
PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits; legal values are 1 and above.
REQ-002 Parameter DEPTH, default 3: number of register stages; legal values are 1 and above.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port res, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port en, input, 1 bit: global enable; when 0, the whole chain holds state.
REQ-006 Port flush, input, 1 bit: synchronous discard of all in-flight entries.
REQ-007 Port in_valid, input, 1 bit: upstream presents in_data.
REQ-008 Port in_data, input, WIDTH bits: upstream payload.
REQ-009 Port in_ready, output, 1 bit: chain accepts in_data this cycle.
REQ-010 Port out_valid, output, 1 bit: out_data holds a valid entry.
REQ-011 Port out_data, output, WIDTH bits: payload of the last stage.
REQ-012 Port out_ready, input, 1 bit: downstream accepts this cycle.
REQ-013 Port count, output, $clog2(DEPTH+1) bits: number of valid stages.

Function
REQ-014 The block SHALL hold DEPTH stages, numbered 0 to DEPTH-1, each with a valid bit v[k] and a WIDTH-bit data register d[k]; stage DEPTH-1 drives out_data and out_valid.
REQ-015 Stage readiness SHALL be defined as: r[DEPTH] = out_ready; r[k] = !v[k] || r[k+1]. This is a combinational chain, so bubbles collapse.
REQ-016 in_ready SHALL equal r[0] && en && !flush && !res.
REQ-017 out_valid SHALL equal v[DEPTH-1] && en && !flush && !res.
REQ-018 out_data SHALL equal d[DEPTH-1] at all times, including when out_valid is 0.
REQ-019 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-020 When en=1, flush=0 and res=0, each stage k with r[k]=1 SHALL load from its predecessor on the clock edge:
  - Stage 0 loads v[0] <= in_valid && in_ready and d[0] <= in_data.
  - Stage k>0 loads v[k] <= v[k-1] and d[k] <= d[k-1].
REQ-021 A stage with r[k]=0 SHALL hold both v[k] and d[k].
REQ-022 A data register SHALL only be written when its stage loads; on a bubble load, d[k] may take the predecessor value, and d[k] is don't-care while v[k]=0.
REQ-023 When en=0, flush=0 and res=0, all v and d SHALL hold, and no transfer SHALL occur on either side.
REQ-024 Latency: an entry accepted at edge N with no downstream stall SHALL present out_valid=1 in the cycle after edge N+DEPTH-1, i.e. DEPTH cycles after acceptance.
REQ-025 Throughput: with en=1 and out_ready held at 1, the chain SHALL accept and deliver one entry per cycle.
REQ-026 Full condition (all v=1 and out_ready=0): in_ready SHALL be 0 and all stages SHALL hold.
REQ-027 Full condition with out_ready=1: in_ready SHALL be 1, and an input and an output transfer SHALL occur in the same cycle.
REQ-028 When flush=1 and res=0, all v[k] SHALL be cleared at the edge regardless of en, d SHALL hold, and no transfer SHALL occur in that cycle.
REQ-029 count SHALL equal the population count of v[0..DEPTH-1], registered, so it reflects state after the last edge.
REQ-030 DEPTH=1 SHALL behave as a single elastic register: in_ready = (!v[0] || out_ready) && en.

Reset
REQ-031 When res=1 at a rising edge, all v[k] SHALL be set to 0 and all d[k] to 0, so count=0 and out_data=0.
REQ-032 Priority SHALL be res > flush > en.
REQ-033 A reset asserted mid-operation SHALL discard all in-flight entries, and in_ready and out_valid SHALL be 0 while res=1.
REQ-034 In the first cycle after res deasserts with en=1, in_ready SHALL be 1.

Verification (WIDTH=8, DEPTH=3)
REQ-035 Streaming: en=1, out_ready=1, in_data 0x11, 0x22, 0x33 on consecutive cycles -> out_data 0x11, 0x22, 0x33 with out_valid=1 on cycles 3, 4, 5 after the first acceptance.
REQ-036 Backpressure: out_ready=0 and 4 entries offered -> 3 accepted, count=3, in_ready=0. Then out_ready=1 -> 0x11 out first, and the 4th entry is accepted in the same cycle.
REQ-037 Bubble collapse: accept 0xA1, idle 2 cycles, accept 0xA2, out_ready=0 -> both entries packed in stages 2 and 1, count=2.
REQ-038 Stall: en=0 for 2 cycles mid-stream with in_valid=1 and out_ready=1 -> in_ready=0, out_valid=0, count unchanged. On resume, the sequence continues with no loss or duplicate.
REQ-039 Flush and reset: count=3, flush=1 with en=0 -> count=0 next cycle. Refill with 0x55, then res=1 together with flush=1 -> count=0, out_data=0x00.
